// File: rtl/i2s_pkg.sv
// Shared widths, sample type and I2S slot decode for the playback transmitter.
package i2s_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned DATA_BITS  = 16;
  localparam int unsigned BITCNT_W   = $clog2(FRAME_BITS);
  localparam int unsigned SLOT_W     = $clog2(SLOT_BITS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Slots 1..16 carry the word MSB first, one BCLK after the LRCLK edge.
  function automatic logic slot_bit(sample_t word, logic [BITCNT_W-1:0] bitcnt);
    logic [SLOT_W-1:0] s;
    logic [3:0]        idx;
    logic              bit_out;
    s       = bitcnt[SLOT_W-1:0];
    idx     = 4'(SLOT_W'(DATA_BITS) - s);
    bit_out = 1'b0;
    if (s >= SLOT_W'(1) && s <= SLOT_W'(DATA_BITS))
      bit_out = word[idx];
    return bit_out;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// MCLK divider, BCLK divider and frame bit counter for the I2S master.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 16,
  parameter int unsigned MCLK_DIV  = 8
) (
  input  logic                clk96M,
  input  logic                reset,
  output logic                bclk,
  output logic                mclk,
  output logic [BITCNT_W-1:0] bitcnt,
  output logic                fall_edge,
  output logic                frame_start
);

  localparam int unsigned DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned MHALF  = MCLK_DIV / 2;
  localparam int unsigned MDIV_W = (MHALF > 1) ? $clog2(MHALF) : 1;

  logic [DIV_W-1:0]  div;
  logic [MDIV_W-1:0] mdiv;
  logic              div_wrap;
  logic              mdiv_wrap;

  assign div_wrap  = (div == DIV_W'(BCLK_HALF - 1));
  assign mdiv_wrap = (mdiv == MDIV_W'(MHALF - 1));

  // Strobes flag the edge on which bclk will fall, so the top can update its registers on that same edge.
  assign fall_edge   = div_wrap && bclk;
  assign frame_start = fall_edge && (bitcnt == BITCNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk96M) begin
    if (reset) begin
      div    <= '0;
      mdiv   <= '0;
      bclk   <= 1'b0;
      mclk   <= 1'b0;
      bitcnt <= '1;
    end else begin
      div  <= div_wrap ? '0 : div + 1'b1;
      mdiv <= mdiv_wrap ? '0 : mdiv + 1'b1;
      if (div_wrap)
        bclk <= ~bclk;
      if (mdiv_wrap)
        mclk <= ~mclk;
      if (fall_edge)
        bitcnt <= bitcnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_playback_tx.sv
// I2S master transmitter: one mono sample per frame, played on both channels.
// Optional underrun counter enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_playback_tx
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 16,
  parameter int unsigned MCLK_DIV  = 8
) (
  input  logic                clk96M,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                mclk,
  output logic                bclk,
  output logic                lrclk,
  output logic                pbdat,
  output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  logic [BITCNT_W-1:0] bitcnt;
  logic [BITCNT_W-1:0] next_bitcnt;
  logic                fall_edge;
  logic                frame_start;
  logic                accept;
  logic                full;
  sample_t             hold;
  sample_t             last;
  sample_t             word;

  i2s_clkgen #(
    .BCLK_HALF (BCLK_HALF),
    .MCLK_DIV  (MCLK_DIV)
  ) u_clkgen (
    .clk96M      (clk96M),
    .reset       (reset),
    .bclk        (bclk),
    .mclk        (mclk),
    .bitcnt      (bitcnt),
    .fall_edge   (fall_edge),
    .frame_start (frame_start)
  );

  assign next_bitcnt = bitcnt + 1'b1;
  assign accept      = sample_valid && sample_ready;

  // Frame load looks at the registered holding state, so an accept on the frame-start edge waits for the next frame.
  always_ff @(posedge clk96M) begin
    if (reset) begin
      hold         <= '0;
      last         <= '0;
      word         <= '0;
      full         <= 1'b0;
      sample_ready <= 1'b1;
      lrclk        <= 1'b0;
      pbdat        <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      underrun     <= frame_start && !full;
      sample_ready <= !accept && !full;
      if (frame_start) begin
        if (full) begin
          word <= hold;
          last <= hold;
          full <= 1'b0;
        end else begin
          word <= last;
        end
      end
      if (accept) begin
        hold <= sample_t'(sample_in);
        full <= 1'b1;
      end
      if (fall_edge) begin
        lrclk <= next_bitcnt[BITCNT_W-1];
        pbdat <= slot_bit(word, next_bitcnt);
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk96M) begin
    if (reset)
      underrun_cnt <= '0;
    else if (underrun && underrun_cnt != '1)
      underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/i2s_playback_tx.md
# i2s_playback_tx

Serialises 16-bit signed audio samples from the synthesizer voice path (sine generator `dout`) into an I2S stream for the on-board SSM2603 codec, which runs in slave mode. It is the I2S master: it generates MCLK, BCLK and LRCLK from `clk96M`. It also drives PBDAT. It pulls one mono sample per frame through a valid/ready handshake and plays it on both channels. It sits between the sample producer and the codec pins, in the `clk96M` domain.

## Interface
- `BCLK_HALF`, default 16: `clk96M` cycles per BCLK half-period. Frame length is 128·BCLK_HALF cycles, so fs = 46 875 Hz at the default.
- `MCLK_DIV`, default 8: `clk96M` cycles per MCLK period, which gives 12 MHz (codec USB mode). Must be even.
- `clk96M`  in  1  system clock, 96 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `sample_in`  in  16  two's-complement sample.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  holding register is empty.
- `mclk`  out  1  codec master clock.
- `bclk`  out  1  bit clock.
- `lrclk`  out  1  0 = left, 1 = right.
- `pbdat`  out  1  serial data.
- `underrun`  out  1  one-cycle pulse at a frame start where no sample was held.
- `underrun_cnt`  out  16  only with `I2S_TX_UNDERRUN_CNT_EN`.

## Operation
- The clock is one `clk96M`, the reset is synchronous and active-high, and all outputs are registered.
- **Reset values:** `mclk` 0, `bclk` 0, `lrclk` 0, `pbdat` 0, `sample_ready` 1, `underrun` 0, `underrun_cnt` 0.
- **Internal reset values:** `div` 0, `bitcnt` 63, holding register empty, `last` 0.
- **MCLK:** free-running and toggles every MCLK_DIV/2 cycles. It is not phase-related to BCLK.
- **BCLK divider:**
  - `div` counts 0..BCLK_HALF−1.
  - When `div` = BCLK_HALF−1, `div` wraps and `bclk` toggles.
- **Falling edge (bclk 1→0):**
  - `bitcnt` increments mod 64.
  - `lrclk` ← new `bitcnt`[5].
  - `pbdat` ← slot bit.
- **Slot map** (s = `bitcnt` mod 32):
  - s = 1..16 carry shift bit 16−s, MSB first, one BCLK after the LRCLK edge (I2S).
  - s = 0 and s = 17..31 carry 0.
  - The same word is sent in the left and right halves.
- **Frame start** is the falling edge where `bitcnt` wraps 63→0:
  - Holding full: the shift word is loaded from holding, `last` takes the same value, and holding is emptied.
  - Holding empty: the shift word is loaded from `last` (the previous sample is repeated) and `underrun` pulses for 1 cycle.
- **Handshake:**
  - A transfer happens when `sample_valid` and `sample_ready` are both high on a rising clock edge.
  - `sample_ready` = holding empty, registered.
  - At most one sample is accepted per frame.
  - The producer must hold `sample_valid` and `sample_in` until accepted.
- **Simultaneous accept and frame start** (holding empty): the frame load uses the registered holding state, so `underrun` fires and `last` is replayed. The accepted sample stays in holding for the next frame.
- **Holding full at frame start:** `sample_ready` rises on the cycle after the frame start.
- **Reset mid-frame:** all state returns to reset values on the next edge and the held sample is discarded.

## Timing
- After `reset` falls, the first `bclk` rise is at cycle BCLK_HALF and the first fall/frame start is at cycle 2·BCLK_HALF.
- `lrclk` and `pbdat` change on the same `clk96M` edge as the `bclk` fall. They are stable for BCLK_HALF cycles before the next rise.
- Latency from sample acceptance to its MSB on `pbdat` is at most 1 frame + 1 BCLK period.
- `underrun` is asserted on the same cycle as the frame-start `bclk` fall.

## Configuration
- `I2S_TX_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` port exists.
  - It counts `underrun` pulses and saturates at 16'hFFFF.
  - It is cleared only by `reset`.
- Macro undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- **Package `i2s_pkg`:**
  - `SAMPLE_W` = 16, `FRAME_BITS` = 64, `SLOT_BITS` = 32, `DATA_BITS` = 16.
  - typedef `sample_t` = logic signed [15:0].
- **Sub-module `i2s_clkgen`:** MCLK divider, BCLK divider and `bitcnt`. It outputs `bclk`, `mclk`, `bitcnt`, a falling-edge strobe and a frame-start strobe.
- **Top level:** holds the holding register, `last`, the slot mux and the handshake.

## Test plan
- **Reset release:** `bclk` rises at cycle 16 and falls at cycle 32. `lrclk`=0, `pbdat`=0, `sample_ready`=1, and `underrun` pulses at cycle 32 (empty holding).
- **Single sample:** push 16'hA5C3 before the second frame start → left slots 1..16 and right slots 1..16 carry 1010_0101_1100_0011. All other slots carry 0, and `lrclk`=1 for `bitcnt` 32..63.
- **Back-to-back:** hold `sample_valid` with 16'h0001, 16'h7FFF, 16'h8000 → exactly one sample is accepted per frame and `sample_ready` is low between accepts. Consecutive frames carry these three words, with no `underrun`.
- **Underrun:** skip one frame after 16'hA5C3 → `underrun` is a 1-cycle pulse at frame start and that frame repeats 16'hA5C3. With the macro, `underrun_cnt` increments by 1.
- **Accept on frame-start cycle** with holding empty: `underrun` fires, `last` is replayed, and the new sample appears in the following frame.
- **Reset at `bitcnt`=20:** outputs take reset values on the next cycle, the held sample is dropped, and the sequence restarts exactly as in the reset-release test.
